// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding used by the
// RTL and by the bench for state checks.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage : pulse_stretch_pkg

// File: rtl/pulse_stretch_down_counter.sv
// Loadable down counter for the hold/gap timer; saturates at zero and flags
// the final counted cycle.
module down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] cnt;

    // NOTE: clocked state is always assigned with <= so every flop samples
    // pre-edge values regardless of the order of statements or blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_one = (cnt == W'(1));

endmodule : down_counter

// File: rtl/pulse_stretch.sv
// Expands a one-cycle request into a level held for max(len,1) cycles,
// optionally followed by a forced low gap, with retrigger or drop policy.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 0,
    parameter bit RETRIG     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] len,
    output logic             lvl,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    if ((GAP_CYCLES < 0) || (longint'(GAP_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_gap
        $error("pulse_stretch: GAP_CYCLES must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] GAP_VAL = CNT_W'(GAP_CYCLES);

    state_t           state;
    logic             is_one;
    logic             load;
    logic             dec;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] len_eff;
    logic             reload;

    assign len_eff = (len == '0) ? CNT_W'(1) : len;
    assign reload  = trig & RETRIG;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        load     = 1'b0;
        dec      = 1'b0;
        load_val = len_eff;
        case (state)
            IDLE: load = trig;
            HOLD: begin
                if (reload) begin
                    load = 1'b1;
                end else if (is_one) begin
                    if (GAP_CYCLES > 0) begin
                        load     = 1'b1;
                        load_val = GAP_VAL;
                    end
                end else begin
                    dec = 1'b1;
                end
            end
            GAP:     dec = !is_one;
            default: load = 1'b0;
        endcase
    end

    down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .is_one   (is_one)
    );

    // Outputs are registered alongside the state so nothing is combinational
    // from trig; a retrigger wins over expiry in the final hold cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            lvl   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= HOLD;
                        lvl   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HOLD: begin
                    drop <= trig & ~RETRIG;
                    if (!reload && is_one) begin
                        done <= 1'b1;
                        lvl  <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    drop <= trig;
                    if (is_one) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    lvl   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : pulse_stretch

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: three parameterisations share inputs,
// expected {lvl,busy,done,drop} per cycle are queued as stimulus is driven.
module tb_pulse_stretch;
    import pulse_stretch_pkg::*;

    localparam int BASE = 0;  // GAP_CYCLES=0, RETRIG=0
    localparam int RT   = 1;  // GAP_CYCLES=0, RETRIG=1
    localparam int GP   = 2;  // GAP_CYCLES=3, RETRIG=0

    typedef struct {
        int         sel;
        int         cyc;
        logic [3:0] o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [15:0] len;
    logic [2:0]  lvl, busy, done, drop;

    exp_t sb[$];
    exp_t e;
    logic [3:0] got;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_stretch #(.CNT_W(16), .GAP_CYCLES(0), .RETRIG(1'b0)) u_base (
        .clk(clk), .rst(rst), .trig(trig), .len(len),
        .lvl(lvl[BASE]), .busy(busy[BASE]), .done(done[BASE]), .drop(drop[BASE]));
    pulse_stretch #(.CNT_W(16), .GAP_CYCLES(0), .RETRIG(1'b1)) u_rt (
        .clk(clk), .rst(rst), .trig(trig), .len(len),
        .lvl(lvl[RT]), .busy(busy[RT]), .done(done[RT]), .drop(drop[RT]));
    pulse_stretch #(.CNT_W(16), .GAP_CYCLES(3), .RETRIG(1'b0)) u_gap (
        .clk(clk), .rst(rst), .trig(trig), .len(len),
        .lvl(lvl[GP]), .busy(busy[GP]), .done(done[GP]), .drop(drop[GP]));

    function automatic logic [3:0] outs(input int sel);
        return {lvl[sel], busy[sel], done[sel], drop[sel]};
    endfunction

    task automatic push(input int sel, input int cyc, input logic [3:0] o);
        exp_t x;
        x.sel = sel;
        x.cyc = cyc;
        x.o   = o;
        sb.push_back(x);
    endtask

    // Apply inputs for the current cycle, then move just past the next edge.
    task automatic drive(input logic t, input logic [15:0] l);
        trig = t;
        len  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'd0);
    endtask

    task automatic test_reset;
        rst = 1'b0; trig = 1'b0; len = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (outs(s) !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outs inst=%0d got=%b exp=0000", s, outs(s));
            end
        end
        checks++;
        if (u_base.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", u_base.state, IDLE);
        end
        rst = 1'b1;
        idle(2);
        checks++;
        if (outs(BASE) !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset got=%b exp=0000", outs(BASE));
        end
    endtask

    // len=5, single trigger; len changes mid-hold must be ignored.
    task automatic test_single;
        for (int c = 1; c <= 8; c++) push(BASE, c, {c <= 5, c <= 5, c == 6, 1'b0});
        for (int c = 0; c < 8; c++) begin
            drive(c == 0, (c == 0) ? 16'd5 : 16'd1);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL single cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
        idle(12);
    endtask

    task automatic test_len_zero;
        for (int c = 1; c <= 4; c++) push(BASE, c, {c == 1, c == 1, c == 2, 1'b0});
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 16'd0);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL len_zero cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
        idle(12);
    endtask

    // Second trig on the 3rd high cycle: RETRIG extends to 3+4, non-retrig drops it.
    task automatic test_retrigger;
        for (int c = 1; c <= 10; c++) begin
            push(RT,   c, {c <= 7, c <= 7, c == 8, 1'b0});
            push(BASE, c, {c <= 4, c <= 4, c == 5, c == 4});
        end
        for (int c = 0; c < 10; c++) begin
            drive(c == 0 || c == 3, 16'd4);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL retrigger cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
        idle(12);
    endtask

    task automatic test_drop;
        for (int c = 1; c <= 7; c++) push(BASE, c, {c <= 4, c <= 4, c == 5, c == 3});
        for (int c = 0; c < 7; c++) begin
            drive(c == 0 || c == 2, 16'd4);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL drop cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
        idle(12);
    endtask

    // G=3, len=2, trig held for cycles 0..9: accepts at 0 and 6 only.
    task automatic test_gap;
        for (int c = 1; c <= 10; c++) begin
            logic l, b, d, dr;
            l  = (c >= 1 && c <= 2) || (c >= 7 && c <= 8);
            b  = (c >= 1 && c <= 5) || (c >= 7 && c <= 11);
            d  = (c == 3) || (c == 9);
            dr = (c - 1 <= 9) && (c - 1 != 0) && (c - 1 != 6);
            push(GP, c, {l, b, d, dr});
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 16'd2);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL gap cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
        idle(12);
    endtask

    // Continuous trig, len=3: G=0/no-retrig gives 3 high, 1 low with drop and
    // done coinciding; retrig keeps lvl high throughout.
    task automatic test_back_to_back;
        for (int c = 1; c <= 11; c++) begin
            push(BASE, c, {(c - 1) % 4 < 3, (c - 1) % 4 < 3, c % 4 == 0, (c - 1) % 4 != 0});
            push(RT,   c, 4'b1100);
        end
        for (int c = 0; c < 11; c++) begin
            drive(1'b1, 16'd3);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL back_to_back cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
        idle(12);
    endtask

    task automatic test_reset_mid_hold;
        for (int c = 1; c <= 3; c++) push(BASE, c, 4'b1100);
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 16'd8);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL pre_reset cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
        #2 rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (outs(s) !== 4'b0000) begin
                errors++;
                $display("FAIL async_reset inst=%0d got=%b exp=0000", s, outs(s));
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 1; c <= 16; c++) push(BASE, c, {c >= 13 && c <= 14, c >= 13 && c <= 14, c == 15, 1'b0});
        for (int c = 0; c < 16; c++) begin
            drive(c == 12, 16'd2);
            while (sb.size() > 0 && sb[0].cyc == c + 1) begin
                e = sb.pop_front();
                got = outs(e.sel);
                checks++;
                if (got !== e.o) begin
                    errors++;
                    $display("FAIL after_reset cyc=%0d inst=%0d got=%b exp=%b", e.cyc, e.sel, got, e.o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_len_zero();
        test_retrigger();
        test_drop();
        test_gap();
        test_back_to_back();
        test_reset_mid_hold();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_pulse_stretch
